// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with per-frame shift counter
module shift_reg_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] pdout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             frame_done
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_RIGHT = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             frame_q, frame_d;
    logic             shifting;

    assign shifting = en && (mode == MODE_RIGHT || mode == MODE_LEFT);

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_RIGHT: q_d = {sin, q_q[WIDTH-1:1]};
                MODE_LEFT:  q_d = {q_q[WIDTH-2:0], sin};
                MODE_LOAD:  q_d = pdin;
                MODE_HOLD:  q_d = q_q;
                default:    q_d = q_q;
            endcase
        end
    end

    // Both shift directions count toward the same frame; load restarts the frame.
    always_comb begin
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        if (en && mode == MODE_LOAD) begin
            cnt_d = '0;
        end else if (shifting) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                frame_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    assign pdout      = q_q;
    assign sout_r     = q_q[0];
    assign sout_l     = q_q[WIDTH-1];
    assign cnt        = cnt_q;
    assign frame_done = frame_q;

endmodule
